img_row_sender: RTL and testbench

IMG_ROW_SENDER -- requirements
Module: img_row_sender

---
 rtl/img_row_sender_pkg.sv | 35 +++
 rtl/img_row_sender_cycle_timer.sv | 30 +++
 rtl/img_row_sender.sv | 155 +++++++++++++++
 tb/tb_img_row_sender.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/img_row_sender_pkg.sv
// rtl/img_row_sender_pkg.sv - shared types, sizes and row formatting for img_row_sender
// Purpose: FSM state enum, image/bus geometry constants and the helper that turns
//          one image row into the 8-bit ui_out word.
// Ports:   none (package).
package img_row_sender_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int N_ROWS    = 5;
    localparam int ROW_W     = 5;
    localparam int IMG_W     = 25;
    localparam int TAG_W     = 3;
    localparam int UI_W      = ROW_W + TAG_W;
    localparam int ROW_IDX_W = 3;
    localparam int CNT_W     = 8;

    // Row k is img[5k+4:5k]; on the bus its bit0 lands on ui_out[7] and the
    // low three bits carry the 1-based row tag (0 is reserved for idle).
    function automatic logic [UI_W-1:0] row_word(input logic [IMG_W-1:0]     im,
                                                 input logic [ROW_IDX_W-1:0] k);
        logic [ROW_W-1:0] r;
        logic [ROW_W-1:0] rev;
        r = ROW_W'(im >> (ROW_W * int'(k)));
        for (int i = 0; i < ROW_W; i++) begin
            rev[ROW_W-1-i] = r[i];
        end
        return {rev, k + ROW_IDX_W'(1)};
    endfunction

endpackage

// File: rtl/img_row_sender_cycle_timer.sv
// rtl/img_row_sender_cycle_timer.sv - loadable down-counter with expire flag
// Purpose: times how long the sender stays in a state; load sets the count,
//          dec steps it toward zero, expired is high while the count is zero.
// Ports:   clk, rst_n (async active-low), load, load_val[W-1:0], dec -> expired.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/img_row_sender.sv
// rtl/img_row_sender.sv - sends a latched 5x5 binary image row by row on an 8-bit bus
// Purpose: on start, latch img and drive each row (bit-reversed, tagged 1..5) for
//          HOLD_CYCLES cycles, then pulse done. Optional inter-row idle gaps of
//          GAP_CYCLES cycles are compiled in with macro IMG_ROW_SENDER_GAP_EN.
// Ports:   clk, rst_n (async active-low), start, img[24:0] ->
//          ui_out[7:0] (row data + tag, 0 when idle), busy, done (1-cycle pulse).
module img_row_sender
    import img_row_sender_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IMG_W-1:0] img,
    output logic [UI_W-1:0]  ui_out,
    output logic             busy,
    output logic             done
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be within 1..255");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("GAP_CYCLES must be within 1..255");
    end

    // Timer is loaded with N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`ifdef IMG_ROW_SENDER_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
`endif

    state_e                 state_q;
    logic [ROW_IDX_W-1:0]   row_q;
    logic [IMG_W-1:0]       img_q;
    logic [UI_W-1:0]        ui_out_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_val;
    logic                   tmr_dec;
    logic                   tmr_expired;

    logic                   last_row;
    logic [ROW_IDX_W-1:0]   row_nxt;

    assign last_row = (row_q == ROW_IDX_W'(N_ROWS - 1));
    assign row_nxt  = row_q + ROW_IDX_W'(1);

    // One timer serves both hold and gap timing; each state entry reloads it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: tmr_load = start;
            SEND: begin
                if (!tmr_expired) begin
                    tmr_dec = 1'b1;
                end else if (!last_row) begin
                    tmr_load = 1'b1;
`ifdef IMG_ROW_SENDER_GAP_EN
                    tmr_val  = GAP_LOAD;
`endif
                end
            end
`ifdef IMG_ROW_SENDER_GAP_EN
            GAP: begin
                if (!tmr_expired) begin
                    tmr_dec = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    cycle_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            img_q    <= '0;
            ui_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Row 0 comes straight from the live input so it is on
                        // the bus the very next cycle; later rows use the copy.
                        img_q    <= img;
                        row_q    <= '0;
                        ui_out_q <= row_word(img, '0);
                        busy_q   <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (tmr_expired) begin
                        if (last_row) begin
                            row_q    <= '0;
                            ui_out_q <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= FIN;
                        end else begin
`ifdef IMG_ROW_SENDER_GAP_EN
                            ui_out_q <= '0;
                            state_q  <= GAP;
`else
                            row_q    <= row_nxt;
                            ui_out_q <= row_word(img_q, row_nxt);
`endif
                        end
                    end
                end
`ifdef IMG_ROW_SENDER_GAP_EN
                GAP: begin
                    if (tmr_expired) begin
                        row_q    <= row_nxt;
                        ui_out_q <= row_word(img_q, row_nxt);
                        state_q  <= SEND;
                    end
                end
`endif
                // start is deliberately not looked at here.
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ui_out = ui_out_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_img_row_sender.sv
// tb/tb_img_row_sender.sv - self-checking bench for img_row_sender
module tb_img_row_sender;

    localparam int H0 = 4;
    localparam int H1 = 1;
`ifdef IMG_ROW_SENDER_GAP_EN
    localparam int G0 = 2;
    localparam int G1 = 1;
`else
    localparam int G0 = 0;
    localparam int G1 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0;
    logic        start1;
    logic [24:0] img;
    logic [7:0]  ui0;
    logic [7:0]  ui1;
    logic        busy0;
    logic        busy1;
    logic        done0;
    logic        done1;

    int checks   = 0;
    int failures = 0;

    // Each entry is {ui_out, busy, done} expected for one cycle.
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    img_row_sender #(.HOLD_CYCLES(H0), .GAP_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .img(img),
        .ui_out(ui0), .busy(busy0), .done(done0)
    );

    img_row_sender #(.HOLD_CYCLES(H1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .img(img),
        .ui_out(ui1), .busy(busy1), .done(done1)
    );

    function automatic logic [7:0] model_row(logic [24:0] im, int k);
        int d;
        int rv;
        d  = int'((im >> (5 * k)) & 25'h1F);
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            if (((d >> i) & 1) == 1) rv += (1 << (4 - i));
        end
        return 8'((rv << 3) + k + 1);
    endfunction

    // Whole frame followed by one idle cycle.
    task automatic add_frame(logic [24:0] im, int hold, int gap);
        for (int k = 0; k < 5; k++) begin
            repeat (hold) exp_q.push_back({model_row(im, k), 2'b10});
            if (k < 4) repeat (gap) exp_q.push_back({8'h00, 2'b10});
        end
        exp_q.push_back({8'h00, 2'b01});
        exp_q.push_back({8'h00, 2'b00});
    endtask

    task automatic check(string tag, logic [9:0] obs, logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_start(int sel, logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    task automatic launch(int sel, logic [24:0] im, bit clobber, bit keep);
        @(negedge clk);
        img = im;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        if (!keep) set_start(sel, 1'b0);
        if (clobber) img = '0;
    endtask

    // mode 0: start low, 1: random start during frame, 2: start left high.
    task automatic play(int sel, int mode, string tag);
        int n;
        logic [9:0] e;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, n),
                  (sel == 1) ? {ui1, busy1, done1} : {ui0, busy0, done0}, e);
            n++;
            if (exp_q.size() == 0)  set_start(sel, 1'b0);
            else if (mode == 1)     set_start(sel, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        logic [24:0] im;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        img    = '0;
        repeat (2) begin
            @(negedge clk);
            check("reset_dut0", {ui0, busy0, done0}, 10'h000);
            check("reset_dut1", {ui1, busy1, done1}, 10'h000);
        end
        rst_n = 1'b1;

        add_frame(25'h1F_0001, H0, G0);
        launch(0, 25'h1F_0001, 1'b0, 1'b0);
        play(0, 0, "frame_1f0001");

        add_frame(25'h1FF_FFFF, H0, G0);
        launch(0, 25'h1FF_FFFF, 1'b0, 1'b0);
        play(0, 0, "frame_ones");

        for (int f = 0; f < 4; f++) begin
            im = 25'($urandom);
            add_frame(im, H0, G0);
            launch(0, im, 1'b0, 1'b0);
            play(0, 1, $sformatf("rand_start_f%0d", f));
        end

        im = 25'($urandom) | 25'h1;
        add_frame(im, H0, G0);
        launch(0, im, 1'b1, 1'b0);
        play(0, 0, "img_changed");

        im = 25'($urandom);
        add_frame(im, H0, G0);
        add_frame(im, H0, G0);
        launch(0, im, 1'b0, 1'b1);
        play(0, 2, "start_held");

        im = 25'($urandom) | 25'h0_7C00;
        launch(0, im, 1'b0, 1'b0);
        repeat (3 * (H0 + G0) + 2) @(negedge clk);
        check("row3_before_rst", {ui0, busy0, done0}, {model_row(im, 3), 2'b10});
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {ui0, busy0, done0}, 10'h000);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {ui0, busy0, done0}, 10'h000);
        end
        rst_n = 1'b1;
        im = 25'($urandom);
        add_frame(im, H0, G0);
        launch(0, im, 1'b0, 1'b0);
        play(0, 0, "after_rst");

        for (int f = 0; f < 3; f++) begin
            im = 25'($urandom);
            add_frame(im, H1, G1);
            launch(1, im, 1'b0, 1'b0);
            play(1, 1, $sformatf("hold1_f%0d", f));
        end

        im = 25'($urandom);
        add_frame(im, H1, G1);
        add_frame(im, H1, G1);
        launch(1, im, 1'b0, 1'b1);
        play(1, 2, "hold1_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
